// File: rtl/ic_sram_port.sv
// Memory-side target for one interconnect master port: decodes req/gnt requests onto a
// single-port synchronous SRAM and returns in-order recv/ack responses via a small FIFO.
module ic_sram_port #(
    parameter logic [31:0] MAP_MATCH = 32'h2000_0000,
    parameter logic [31:0] MAP_MASK  = 32'hFFFF_0000,
    parameter int unsigned SRAM_AW   = 14,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic               g_clk,
    input  logic               g_resetn,
    input  logic               mem_req,
    input  logic               mem_wen,
    input  logic [3:0]         mem_strb,
    input  logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_addr,
    output logic               mem_gnt,
    output logic               mem_recv,
    input  logic               mem_ack,
    output logic               mem_error,
    output logic [31:0]        mem_rdata,
    output logic               sram_cen,
    output logic               sram_wen,
    output logic [3:0]         sram_strb,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
);

    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic                 inflight_q, inflight_d;
    logic                 pend_err_q, pend_err_d;
    logic                 pend_wr_q, pend_wr_d;
    logic [31:0]          fifo_data_q [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] fifo_err_q;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;

    logic             hit, bad;
    logic [OCC_W-1:0] occ;
    logic             fifo_empty;
    logic [31:0]      cur_rdata;
    logic             push, pop;

    // Request decode and acceptance
    assign hit     = (mem_addr & MAP_MASK) == MAP_MATCH;
    assign bad     = !hit || (mem_addr[1:0] != 2'b00);
    assign occ     = OCC_W'(inflight_q) + OCC_W'(fifo_cnt_q);
    assign mem_gnt = mem_req && (occ < OCC_W'(RSP_DEPTH));

    assign sram_cen   = mem_gnt && !bad;
    assign sram_wen   = mem_wen;
    assign sram_strb  = mem_strb;
    assign sram_addr  = mem_addr[SRAM_AW+1:2];
    assign sram_wdata = mem_wdata;

    // Response word of the previous-cycle accept; writes and errors return zero data
    assign cur_rdata  = (pend_err_q || pend_wr_q) ? 32'h0 : sram_rdata;
    assign fifo_empty = (fifo_cnt_q == '0);

    // FIFO head has priority; the fresh word bypasses only when nothing is buffered
    assign mem_recv  = !fifo_empty || inflight_q;
    assign mem_error = !fifo_empty ? fifo_err_q[rd_ptr_q]  : (inflight_q && pend_err_q);
    assign mem_rdata = !fifo_empty ? fifo_data_q[rd_ptr_q] : (inflight_q ? cur_rdata : 32'h0);

    assign pop  = !fifo_empty && mem_ack;
    assign push = inflight_q && !(fifo_empty && mem_ack);

    always_comb begin
        inflight_d = mem_gnt;
        pend_err_d = pend_err_q;
        pend_wr_d  = pend_wr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (mem_gnt) begin
            pend_err_d = bad;
            pend_wr_d  = mem_wen;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            inflight_q <= 1'b0;
            pend_err_q <= 1'b0;
            pend_wr_q  <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            pend_err_q <= pend_err_d;
            pend_wr_q  <= pend_wr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_err_q <= '0;
        end else if (push) begin
            fifo_data_q[wr_ptr_q] <= cur_rdata;
            fifo_err_q[wr_ptr_q]  <= pend_err_q;
        end
    end

    a_fifo_bound: assert property (@(posedge g_clk) disable iff (!g_resetn)
        fifo_cnt_q <= CNT_W'(RSP_DEPTH));
    a_occ_bound: assert property (@(posedge g_clk) disable iff (!g_resetn)
        occ <= OCC_W'(RSP_DEPTH));
    a_no_pop_empty: assert property (@(posedge g_clk) disable iff (!g_resetn)
        pop |-> !fifo_empty);

endmodule

// File: tb/tb_ic_sram_port.sv
// Bench for ic_sram_port: directed vector table, reset corner case and randomized traffic
// checked against a queue-based response model with its own copy of memory contents.
module tb_ic_sram_port;

    localparam logic [31:0] A = 32'h2000_0000;

    logic        g_clk, g_resetn;
    logic        mem_req, mem_wen, mem_ack;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wdata, mem_addr;
    logic        mem_gnt, mem_recv, mem_error;
    logic [31:0] mem_rdata;
    logic        sram_cen, sram_wen;
    logic [3:0]  sram_strb;
    logic [13:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;

    ic_sram_port dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_strb(mem_strb),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_recv(mem_recv), .mem_ack(mem_ack), .mem_error(mem_error),
        .mem_rdata(mem_rdata), .sram_cen(sram_cen), .sram_wen(sram_wen),
        .sram_strb(sram_strb), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // SRAM macro: 1-cycle read latency, byte-enabled writes
    logic [31:0] sram_mem [16384];
    always @(posedge g_clk) begin
        if (sram_cen) begin
            if (sram_wen) begin
                for (int b = 0; b < 4; b++)
                    if (sram_strb[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic        req, wen;
        logic [3:0]  strb;
        logic [31:0] wdata, addr;
        logic        ack;
        logic        gnt, cen, recv, err;
        logic [31:0] rdata;
    } vec_t;

    logic [31:0] ref_mem [16384];
    rsp_t        exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive, sample at negedge, check against model, advance model
    task automatic step(input logic req, input logic wen, input logic [3:0] strb,
                        input logic [31:0] wdata, input logic [31:0] addr, input logic ack,
                        output logic o_gnt, output logic o_cen, output logic o_recv,
                        output logic o_err, output logic [31:0] o_rdata);
        logic        e_recv, e_gnt, e_bad, e_err;
        logic [31:0] e_rdata;
        logic [13:0] idx;
        rsp_t        r;
        mem_req = req; mem_wen = wen; mem_strb = strb;
        mem_wdata = wdata; mem_addr = addr; mem_ack = ack;
        @(negedge g_clk);
        o_gnt = mem_gnt; o_cen = sram_cen; o_recv = mem_recv;
        o_err = mem_error; o_rdata = mem_rdata;
        e_recv  = exp_q.size() != 0;
        e_err   = e_recv ? exp_q[0].err : 1'b0;
        e_rdata = e_recv ? exp_q[0].data : 32'h0;
        e_bad   = ((addr & 32'hFFFF_0000) != A) || (addr[1:0] != 2'b00);
        e_gnt   = req && (exp_q.size() < 2);
        idx     = addr[15:2];
        chk("gnt", 32'(mem_gnt), 32'(e_gnt));
        chk("sram_cen", 32'(sram_cen), 32'(e_gnt && !e_bad));
        chk("recv", 32'(mem_recv), 32'(e_recv));
        chk("error", 32'(mem_error), 32'(e_err));
        chk("rdata", mem_rdata, e_rdata);
        if (e_gnt && !e_bad) chk("sram_addr", 32'(sram_addr), 32'(idx));
        if (e_recv && ack) void'(exp_q.pop_front());
        if (e_gnt) begin
            r.err  = e_bad;
            r.data = 32'h0;
            if (!e_bad) begin
                if (wen) begin
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end else begin
                    r.data = ref_mem[idx];
                end
            end
            exp_q.push_back(r);
        end
        @(posedge g_clk);
        #1;
    endtask

    function automatic vec_t mk(input logic req, input logic wen, input logic [3:0] strb,
                                input logic [31:0] wdata, input logic [31:0] addr,
                                input logic ack, input logic gnt, input logic cen,
                                input logic recv, input logic err, input logic [31:0] rdata);
        vec_t v;
        v.req = req; v.wen = wen; v.strb = strb; v.wdata = wdata; v.addr = addr;
        v.ack = ack; v.gnt = gnt; v.cen = cen; v.recv = recv; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [19];
        logic        g, c, rv, er;
        logic [31:0] rd;
        logic        p_valid, p_wen;
        logic [3:0]  p_strb;
        logic [31:0] p_wdata, p_addr;
        int          sel;

        for (int i = 0; i < 16384; i++) begin
            sram_mem[i] = 32'h5A5A_0000 | 32'(i);
            ref_mem[i]  = 32'h5A5A_0000 | 32'(i);
        end
        sram_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4]  = 32'hDEAD_BEEF;
        sram_rdata  = 32'h0;

        tbl[0]  = mk(1, 0, 4'h0, 32'h0,         A + 32'h10,    1, 1, 1, 0, 0, 32'h0);
        tbl[1]  = mk(0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 0, 1, 0, 32'hDEAD_BEEF);
        tbl[2]  = mk(1, 1, 4'h3, 32'h1122_3344, A + 32'h8,     1, 1, 1, 0, 0, 32'h0);
        tbl[3]  = mk(1, 0, 4'h0, 32'h0,         A + 32'h8,     1, 1, 1, 1, 0, 32'h0);
        tbl[4]  = mk(0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 0, 1, 0, 32'h5A5A_3344);
        tbl[5]  = mk(1, 0, 4'h0, 32'h0,         32'h3000_0000, 1, 1, 0, 0, 0, 32'h0);
        tbl[6]  = mk(1, 0, 4'h0, 32'h0,         A + 32'h2,     1, 1, 0, 1, 1, 32'h0);
        tbl[7]  = mk(0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 0, 1, 1, 32'h0);
        tbl[8]  = mk(0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 0, 0, 0, 32'h0);
        tbl[9]  = mk(1, 0, 4'h0, 32'h0,         A,             0, 1, 1, 0, 0, 32'h0);
        tbl[10] = mk(1, 0, 4'h0, 32'h0,         A + 32'h4,     0, 1, 1, 1, 0, 32'h5A5A_0000);
        tbl[11] = mk(1, 0, 4'h0, 32'h0,         A + 32'h8,     0, 0, 0, 1, 0, 32'h5A5A_0000);
        tbl[12] = mk(1, 0, 4'h0, 32'h0,         A + 32'h8,     1, 0, 0, 1, 0, 32'h5A5A_0000);
        tbl[13] = mk(1, 0, 4'h0, 32'h0,         A + 32'h8,     0, 1, 1, 1, 0, 32'h5A5A_0001);
        tbl[14] = mk(1, 0, 4'h0, 32'h0,         A + 32'hC,     0, 0, 0, 1, 0, 32'h5A5A_0001);
        tbl[15] = mk(1, 0, 4'h0, 32'h0,         A + 32'hC,     1, 0, 0, 1, 0, 32'h5A5A_0001);
        tbl[16] = mk(1, 0, 4'h0, 32'h0,         A + 32'hC,     1, 1, 1, 1, 0, 32'h5A5A_3344);
        tbl[17] = mk(0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 0, 1, 0, 32'h5A5A_0003);
        tbl[18] = mk(0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 0, 0, 0, 32'h0);

        g_resetn = 1'b0;
        mem_req = 0; mem_wen = 0; mem_strb = 0; mem_wdata = 0; mem_addr = 0; mem_ack = 0;
        repeat (3) @(posedge g_clk);
        #1;
        chk("reset_recv", 32'(mem_recv), 32'h0);
        chk("reset_error", 32'(mem_error), 32'h0);
        chk("reset_rdata", mem_rdata, 32'h0);
        chk("reset_cen", 32'(sram_cen), 32'h0);
        g_resetn = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].req, tbl[i].wen, tbl[i].strb, tbl[i].wdata, tbl[i].addr, tbl[i].ack,
                 g, c, rv, er, rd);
            chk($sformatf("tbl%0d_gnt", i), 32'(g), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_cen", i), 32'(c), 32'(tbl[i].cen));
            chk($sformatf("tbl%0d_recv", i), 32'(rv), 32'(tbl[i].recv));
            chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].err));
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
        end

        // Streaming reads with ack held high: no bubbles
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 4'h0, 32'h0, A + 32'(4 * (k + 16)), 1, g, c, rv, er, rd);
            chk("stream_gnt", 32'(g), 32'h1);
            if (k > 0) chk("stream_recv", 32'(rv), 32'h1);
        end
        step(0, 0, 4'h0, 32'h0, 32'h0, 1, g, c, rv, er, rd);

        // Reset with two responses buffered
        step(1, 0, 4'h0, 32'h0, A, 0, g, c, rv, er, rd);
        step(1, 0, 4'h0, 32'h0, A + 32'h4, 0, g, c, rv, er, rd);
        step(0, 0, 4'h0, 32'h0, 32'h0, 0, g, c, rv, er, rd);
        chk("prereset_buffered", 32'(exp_q.size()), 32'h2);
        mem_req = 0; mem_ack = 0;
        #2 g_resetn = 1'b0;
        #1;
        chk("midreset_recv", 32'(mem_recv), 32'h0);
        chk("midreset_rdata", mem_rdata, 32'h0);
        exp_q.delete();
        @(posedge g_clk);
        @(posedge g_clk);
        #1 g_resetn = 1'b1;
        step(0, 0, 4'h0, 32'h0, 32'h0, 1, g, c, rv, er, rd);
        step(0, 0, 4'h0, 32'h0, 32'h0, 1, g, c, rv, er, rd);
        chk("postreset_idle_recv", 32'(rv), 32'h0);
        step(1, 0, 4'h0, 32'h0, A + 32'h4, 1, g, c, rv, er, rd);
        step(0, 0, 4'h0, 32'h0, 32'h0, 1, g, c, rv, er, rd);
        chk("postreset_recv", 32'(rv), 32'h1);
        chk("postreset_rdata", rd, 32'h5A5A_0001);

        // Randomized traffic; requester holds its payload until granted
        p_valid = 0; p_wen = 0; p_strb = 0; p_wdata = 0; p_addr = 0;
        for (int n = 0; n < 400; n++) begin
            if (!p_valid && ($urandom % 10) < 6) begin
                p_valid = 1;
                p_wen   = ($urandom % 10) < 4;
                p_strb  = 4'($urandom);
                p_wdata = $urandom;
                sel     = int'($urandom % 10);
                p_addr  = A | (32'($urandom % 64) << 2);
                if (sel == 8) p_addr = 32'h4000_0000 | (32'($urandom % 64) << 2);
                if (sel == 9) p_addr = p_addr | 32'(1 + $urandom % 3);
            end
            step(p_valid, p_wen, p_strb, p_wdata, p_addr, ($urandom % 3) != 0,
                 g, c, rv, er, rd);
            if (g) p_valid = 0;
        end
        for (int n = 0; n < 4; n++) step(0, 0, 4'h0, 32'h0, 32'h0, 1, g, c, rv, er, rd);
        chk("drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ic_sram_port.md
Name: ic_sram_port

Overview:
- Memory-side target for one interconnect master port, e.g. the RAM instruction port driven by the interconnect top.
- Consumes the req/gnt request channel and produces the recv/ack response channel.
- Drives a single-port synchronous SRAM macro with 1-cycle read latency.
- Buffers responses the CPU has not yet acked, flags decode/alignment errors, and back-pressures via gnt.

Parameters:
- MAP_MATCH, 32'h2000_0000, base address of the mapped window
- MAP_MASK, 32'hFFFF_0000, address bits compared against MAP_MATCH
- SRAM_AW, 14, SRAM word-address width (64 KiB at 4 B/word)
- RSP_DEPTH, 2, max outstanding responses (in-flight plus buffered); power of two, at least 2

Ports:
- g_clk  in  1  clock
- g_resetn  in  1  asynchronous active-low reset
- mem_req  in  1  request valid
- mem_wen  in  1  write enable
- mem_strb  in  4  byte write strobe
- mem_wdata  in  32  write data
- mem_addr  in  32  byte address
- mem_gnt  out  1  request accepted this cycle
- mem_recv  out  1  response valid
- mem_ack  in  1  response consumed
- mem_error  out  1  response is an error; valid with mem_recv
- mem_rdata  out  32  read data; valid with mem_recv
- sram_cen  out  1  SRAM chip enable, active high
- sram_wen  out  1  SRAM write enable
- sram_strb  out  4  SRAM byte enables
- sram_addr  out  SRAM_AW  SRAM word address, taken from mem_addr[SRAM_AW+1:2]
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after a read enable

Behaviour:
- **Clock/reset:** One clock, g_clk. g_resetn is asynchronous, active low. All state clears on reset.
- **Reset values:** mem_recv=0, mem_error=0, mem_rdata=0, sram_cen=0, occupancy=0, FIFO empty.
- **Occupancy:** occ = inflight (1-bit register) + fifo_count.
- **Accept:** mem_gnt = mem_req && (occ < RSP_DEPTH). Combinational. Does not depend on mem_ack in the same cycle.
- **Decode (combinational, cycle N):**
  - hit = (mem_addr & MAP_MASK) == MAP_MATCH
  - bad = !hit || (mem_addr[1:0] != 0)
  - Address bits above SRAM_AW+1 inside the window alias; they are not an error.
- **SRAM drive:**
  - sram_cen = mem_gnt && !bad.
  - sram_wen/strb/addr/wdata are passthroughs of mem_*.
  - A write with strb=0 still asserts sram_cen.
  - Bad accepted requests never enable the SRAM.
- **Response capture:**
  - On accept in cycle N, register inflight=1, pend_err=bad, pend_wr=mem_wen.
  - In cycle N+1 the response word is: rdata = (pend_err || pend_wr) ? 0 : sram_rdata; error = pend_err.
- **Response presentation:**
  - If the FIFO is empty, the N+1 word is presented directly: mem_recv=1 in N+1. This is the minimum latency, 1 cycle.
  - If mem_ack is low in that cycle, the word is pushed into the FIFO.
  - If the FIFO is non-empty, the N+1 word is pushed and the FIFO head is presented. Ordering is strict FIFO.
- **Handshake:**
  - A response completes on mem_recv && mem_ack.
  - mem_recv, mem_error and mem_rdata hold stable until acked.
  - mem_ack while mem_recv=0 is ignored.
- **Writes:** also return exactly one response (rdata=0, error as decoded).
- **Simultaneous events:**
  - A push and a pop in the same cycle keep fifo_count unchanged.
  - inflight clears and sets in the same cycle on back-to-back accepts.
- **Throughput:** with mem_ack held high, one accept per cycle is sustained.
- **Full:** at occ==RSP_DEPTH, mem_gnt=0 while mem_req is held. The requester keeps its payload stable until granted.
- **Overflow:** FIFO overflow is impossible by construction. Formal assertions must check fifo_count <= RSP_DEPTH and no pop when empty.
- **Reset mid-operation:** in-flight and buffered responses are discarded. No recv after reset until a new accept.

Test Plan:
1. Read 0x2000_0010 with SRAM word 4 = 0xDEAD_BEEF, ack high → gnt in cycle 0; sram_cen=1, sram_addr=4; cycle 1 recv=1, rdata=0xDEAD_BEEF, error=0.
2. Write 0x2000_0008 wdata=0x1122_3344 strb=4'b0011, then read the same address → write response rdata=0, error=0; read returns 0x????_3344 with the upper bytes unchanged from the preload.
3. Read 0x3000_0000, then read 0x2000_0002 → both granted, sram_cen=0 for both, recv with error=1, rdata=0.
4. Four back-to-back reads to words 0-3 with ack low, RSP_DEPTH=2 → gnt for the first two only; then ack for 1 cycle → one response popped and one further gnt; responses arrive in address order.
5. Continuous reads with ack always high → gnt every cycle; recv every cycle from cycle 1; no bubbles.
6. Assert g_resetn low asynchronously with 2 responses buffered → mem_recv=0 immediately; after release, first recv only follows a new accept.
